// File: rtl/l2_bus_arbiter_pkg.sv
// l2_arb_pkg: shared types and constants for the L2 bus arbiter.
//   state_t      - arbiter FSM states
//   OPC_*        - RISC-V opcodes the arbiter recognises
//   hit_status_t - encoding of the L2 cache_hit_out bus
package l2_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        FLUSH_ISSUE,
        WAIT_RESP,
        RESP
    } state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        HS_NONE = 2'b00,
        HS_MISS = 2'b01,
        HS_HIT  = 2'b10
    } hit_status_t;

endpackage

// File: rtl/l2_bus_arbiter_if.sv
// l2_bus_arbiter_if: core-side request/response bundle plus the L2 bus.
//   master - arbiter view (drives grants, done/err/rdata and the l2_* fields)
//   slave  - core/L2 view (drives requests and the L2 response)
interface l2_bus_arbiter_if #(
    parameter int NUM_CORES = 2
);
    import l2_arb_pkg::*;

    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_flush;
    logic [NUM_CORES-1:0][6:0]   core_opcode;
    logic [NUM_CORES-1:0][31:0]  core_address;
    logic [NUM_CORES-1:0][31:0]  core_data;
    logic [NUM_CORES-1:0][23:0]  core_tag;
    logic [NUM_CORES-1:0]        core_gnt;
    logic [NUM_CORES-1:0]        core_done;
    logic                        core_err;
    logic [31:0]                 core_rdata;

    logic                        l2_flush;
    logic [6:0]                  l2_opcode;
    logic [31:0]                 l2_address;
    logic [31:0]                 l2_data;
    logic [23:0]                 l2_tag;
    hit_status_t                 l2_hit_status;
    logic [31:0]                 l2_rdata;

    modport master (
        input  core_req, core_flush, core_opcode, core_address, core_data, core_tag,
        input  l2_hit_status, l2_rdata,
        output core_gnt, core_done, core_err, core_rdata,
        output l2_flush, l2_opcode, l2_address, l2_data, l2_tag
    );

    modport slave (
        output core_req, core_flush, core_opcode, core_address, core_data, core_tag,
        output l2_hit_status, l2_rdata,
        input  core_gnt, core_done, core_err, core_rdata,
        input  l2_flush, l2_opcode, l2_address, l2_data, l2_tag
    );

endinterface

// File: rtl/l2_bus_arbiter_rr.sv
// rr_arbiter: round-robin pick over NUM_CORES requesters.
//   clk, reset - clock, synchronous active-high reset (pointer -> 0)
//   req        - request vector
//   advance    - move pointer to adv_idx+1 (wrapping)
//   adv_idx    - index of the requester just served
//   valid/idx  - combinational pick: first requester at or after the pointer
module rr_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] req,
    input  logic                 advance,
    input  logic [IDX_W-1:0]     adv_idx,
    output logic                 valid,
    output logic [IDX_W-1:0]     idx
);
    logic [IDX_W-1:0] ptr;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NUM_CORES) j = j - NUM_CORES;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (advance)
            ptr <= (adv_idx == IDX_W'(NUM_CORES - 1)) ? '0 : adv_idx + 1'b1;
    end

endmodule

// File: rtl/l2_bus_arbiter.sv
// l2_bus_arbiter: shares one L2 port among NUM_CORES L1 caches.
//   clk, reset - clock, synchronous active-high reset
//   bus        - core request/response vectors and the L2 bus (master view)
// A granted core's fields are latched in IDLE, then sequenced through
// FLUSH_ISSUE or ISSUE/WAIT_RESP, finishing with a one-cycle done in RESP.
module l2_bus_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    l2_bus_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] gnt_idx, pick_idx;
    logic             pick_valid;
    logic [31:0]      addr_q, data_q, rdata_q;
    logic [23:0]      tag_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt;
    logic             hit, expired;

    assign hit     = (bus.l2_hit_status == HS_HIT);
    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

    rr_arbiter #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.core_req),
        .advance (state == RESP),
        .adv_idx (gnt_idx),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_valid) begin
                if (bus.core_flush[pick_idx])                  state_nxt = FLUSH_ISSUE;
                else if (bus.core_opcode[pick_idx] == OPC_LOAD) state_nxt = ISSUE;
                else                                           state_nxt = RESP;
            end
            FLUSH_ISSUE: state_nxt = RESP;
            ISSUE:       state_nxt = WAIT_RESP;
            WAIT_RESP:   if (hit || expired) state_nxt = RESP;
            RESP:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Transaction context; the core's inputs are only sampled in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_idx <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    gnt_idx <= pick_idx;
                    addr_q  <= bus.core_address[pick_idx];
                    data_q  <= bus.core_data[pick_idx];
                    tag_q   <= bus.core_tag[pick_idx];
                    rdata_q <= '0;
                    err_q   <= !bus.core_flush[pick_idx] &&
                               (bus.core_opcode[pick_idx] != OPC_LOAD);
                end
                ISSUE: cnt <= '0;
                WAIT_RESP: begin
                    // A hit on the last allowed cycle still wins over the timeout.
                    if (hit)          rdata_q <= bus.l2_rdata;
                    else if (expired) err_q   <= 1'b1;
                    else              cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.core_gnt   = '0;
        bus.core_done  = '0;
        bus.core_err   = 1'b0;
        bus.core_rdata = '0;
        bus.l2_flush   = 1'b0;
        bus.l2_opcode  = '0;
        bus.l2_address = '0;
        bus.l2_data    = '0;
        bus.l2_tag     = '0;
        if (state != IDLE) bus.core_gnt[gnt_idx] = 1'b1;
        case (state)
            FLUSH_ISSUE: begin
                bus.l2_flush   = 1'b1;
                bus.l2_address = addr_q;
                bus.l2_data    = data_q;
                bus.l2_tag     = tag_q;
            end
            ISSUE, WAIT_RESP: begin
                bus.l2_opcode  = OPC_LOAD;
                bus.l2_address = addr_q;
                bus.l2_tag     = tag_q;
            end
            RESP: begin
                bus.core_done[gnt_idx] = 1'b1;
                bus.core_err           = err_q;
                bus.core_rdata         = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// tb_l2_bus_arbiter: directed stimulus with a done-pulse scoreboard.
// Stimulus pushes the expected (core, rdata, err, cycle) of each completion;
// a negedge monitor pops and compares on every core_done pulse and also
// checks bus invariants and the l2_* fields against the current transaction.
module tb_l2_bus_arbiter;
    import l2_arb_pkg::*;

    localparam int N  = 2;
    localparam int TO = 16;

    typedef struct {
        int          core;
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];

    logic [31:0] exp_faddr, exp_fdata, exp_laddr;
    logic [23:0] exp_ftag, exp_ltag;
    int          miss_n = 0;
    bit          never_hit = 1'b0;
    logic [31:0] l2_val = '0;
    int          ld_cnt = 0;
    int          flush_total = 0;
    int          load_total = 0;
    bit          prev_flush = 1'b0;

    l2_bus_arbiter_if #(.NUM_CORES(N)) bus ();

    l2_bus_arbiter #(.NUM_CORES(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // L2 model: answers miss for miss_n WAIT_RESP cycles, then hit.
    always @(negedge clk) begin
        if (bus.l2_opcode == OPC_LOAD) ld_cnt = ld_cnt + 1;
        else                           ld_cnt = 0;
        if (ld_cnt == 0)                              bus.l2_hit_status = HS_NONE;
        else if (!never_hit && ld_cnt >= miss_n + 2)  bus.l2_hit_status = HS_HIT;
        else                                          bus.l2_hit_status = HS_MISS;
        bus.l2_rdata = l2_val;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        chk("gnt_onehot", 64'($countones(bus.core_gnt) <= 1), 64'd1);
        chk("flush_vs_opcode", 64'(bus.l2_flush && bus.l2_opcode != 7'd0), 64'd0);
        chk("flush_one_cycle", 64'(bus.l2_flush && prev_flush), 64'd0);
        prev_flush = bus.l2_flush;
        if (bus.l2_flush) begin
            flush_total++;
            chk("flush_fields", {bus.l2_address, bus.l2_data}, {exp_faddr, exp_fdata});
            chk("flush_tag", 64'(bus.l2_tag), 64'(exp_ftag));
        end
        if (bus.l2_opcode == OPC_LOAD) begin
            load_total++;
            chk("load_fields", {bus.l2_address, 8'h0, bus.l2_tag}, {exp_laddr, 8'h0, exp_ltag});
        end
        if (bus.core_done != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'(bus.core_done), 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_core", 64'(bus.core_done), 64'(1) << e.core);
                chk("done_rdata_err", {31'h0, bus.core_err, bus.core_rdata},
                    {31'h0, e.err, e.rdata});
                chk("done_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic set_core(input int core, input bit fl, input logic [6:0] opc,
                            input logic [31:0] a, input logic [31:0] d, input logic [23:0] t);
        bus.core_flush[core]   = fl;
        bus.core_opcode[core]  = opc;
        bus.core_address[core] = a;
        bus.core_data[core]    = d;
        bus.core_tag[core]     = t;
    endtask

    task automatic push(input int core, input logic [31:0] rd, input logic err, input int lat);
        exp_t e;
        e.core = core; e.rdata = rd; e.err = err; e.at = cyc + lat;
        sbq.push_back(e);
    endtask

    task automatic wait_done(input int core, input string name);
        int n = 0;
        while (bus.core_done[core] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({name, "_timeout"}, 64'd0, 64'd1);
        bus.core_req = '0;
    endtask

    task automatic check_zero(input string name);
        chk(name, 64'({bus.core_gnt, bus.core_done, bus.core_err, bus.l2_flush,
                       bus.l2_opcode} != '0 ||
                      {bus.core_rdata, bus.l2_address, bus.l2_data, bus.l2_tag} != '0), 64'd0);
    endtask

    initial begin
        int f0, l0, n, got;
        reset = 1'b1;
        bus.core_req = '0;
        for (int c = 0; c < N; c++) set_core(c, 1'b0, 7'd0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // 1: core0 flush, done 2 cycles after request.
        exp_faddr = 32'h0000_0104; exp_fdata = 32'hDEAD_BEEF; exp_ftag = 24'h000001;
        set_core(0, 1'b1, 7'd0, exp_faddr, exp_fdata, exp_ftag);
        f0 = flush_total;
        bus.core_req = 2'b01;
        push(0, 32'h0, 1'b0, 2);
        wait_done(0, "t1");
        chk("t1_flush_cycles", 64'(flush_total - f0), 64'd1);
        @(negedge clk);

        // 2: core1 load, immediate hit.
        exp_laddr = 32'h0000_2000; exp_ltag = 24'h0000AB;
        miss_n = 0; never_hit = 1'b0; l2_val = 32'h1234_5678;
        set_core(1, 1'b0, OPC_LOAD, exp_laddr, 32'h0, exp_ltag);
        l0 = load_total;
        bus.core_req = 2'b10;
        push(1, 32'h1234_5678, 1'b0, 3);
        wait_done(1, "t2");
        chk("t2_load_cycles", 64'(load_total - l0), 64'd2);
        @(negedge clk);

        // 3: core1 load, 4 miss cycles then hit.
        exp_laddr = 32'h0000_3040; exp_ltag = 24'h000C0F;
        miss_n = 4; l2_val = 32'hCAFE_F00D;
        set_core(1, 1'b0, OPC_LOAD, exp_laddr, 32'h0, exp_ltag);
        l0 = load_total;
        bus.core_req = 2'b10;
        push(1, 32'hCAFE_F00D, 1'b0, 7);
        wait_done(1, "t3");
        chk("t3_load_cycles", 64'(load_total - l0), 64'd6);
        @(negedge clk);

        // 4: both cores request continuously; pointer is 0 so grants go 0,1,0,1,0,1.
        exp_faddr = 32'h0000_0500; exp_fdata = 32'h1111_2222; exp_ftag = 24'h000005;
        exp_laddr = 32'h0000_0600; exp_ltag = 24'h000006;
        miss_n = 0; l2_val = 32'h0BAD_F00D;
        set_core(0, 1'b1, 7'd0, exp_faddr, exp_fdata, exp_ftag);
        set_core(1, 1'b0, OPC_LOAD, exp_laddr, 32'h0, exp_ltag);
        bus.core_req = 2'b11;
        push(0, 32'h0, 1'b0, 2);
        push(1, 32'h0BAD_F00D, 1'b0, 6);
        push(0, 32'h0, 1'b0, 9);
        push(1, 32'h0BAD_F00D, 1'b0, 13);
        push(0, 32'h0, 1'b0, 16);
        push(1, 32'h0BAD_F00D, 1'b0, 20);
        n = 0; got = 0;
        while (got < 6 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.core_done != '0) got++;
        end
        chk("t4_done_count", 64'(got), 64'd6);
        bus.core_req = '0;
        @(negedge clk);

        // 5: core0 load never hits -> timeout TIMEOUT cycles into WAIT_RESP.
        exp_laddr = 32'h0000_0700; exp_ltag = 24'h000007;
        never_hit = 1'b1; l2_val = 32'hFFFF_FFFF;
        set_core(0, 1'b0, OPC_LOAD, exp_laddr, 32'h0, exp_ltag);
        l0 = load_total;
        bus.core_req = 2'b01;
        push(0, 32'h0, 1'b1, TO + 2);
        wait_done(0, "t5");
        chk("t5_load_cycles", 64'(load_total - l0), 64'(TO + 1));
        @(negedge clk);

        // 5b: illegal opcode (store without flush) -> err on the next cycle.
        set_core(0, 1'b0, OPC_STORE, 32'h0000_0A00, 32'h0, 24'h00000A);
        bus.core_req = 2'b01;
        push(0, 32'h0, 1'b1, 1);
        wait_done(0, "t5b");
        @(negedge clk);

        // 6: pointer is now 1; core1 load aborted by reset in WAIT_RESP.
        exp_laddr = 32'h0000_0800; exp_ltag = 24'h000008;
        set_core(1, 1'b0, OPC_LOAD, exp_laddr, 32'h0, exp_ltag);
        bus.core_req = 2'b10;
        repeat (5) @(negedge clk);
        chk("t6_in_wait", 64'(bus.l2_opcode), 64'(OPC_LOAD));
        reset = 1'b1;
        bus.core_req = '0;
        @(negedge clk);
        check_zero("t6_reset_abort");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        never_hit = 1'b0; miss_n = 0; l2_val = 32'h5A5A_5A5A;
        exp_laddr = 32'h0000_0900; exp_ltag = 24'h000009;
        set_core(0, 1'b0, OPC_LOAD, exp_laddr, 32'h0, exp_ltag);
        set_core(1, 1'b0, OPC_LOAD, 32'h0000_0B00, 32'h0, 24'h00000B);
        bus.core_req = 2'b11;
        push(0, 32'h5A5A_5A5A, 1'b0, 3);
        wait_done(0, "t6_after");
        repeat (4) @(negedge clk);

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
